// File: rtl/mem_serial_bridge_if.sv
// mem_serial_bridge_if: request/response ports of the instruction and data clients
// plus the narrow serial link. The bridge uses the slave modport; the client/link
// side uses the master modport.
interface mem_serial_bridge_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LANE_W = 4
);
  localparam int unsigned STRB_W = DATA_W / 8;

  // instruction fetch port
  logic [ADDR_W-1:0] inst_qaddr;
  logic              inst_qvalid;
  logic              inst_qready;
  logic [DATA_W-1:0] inst_pdata;
  logic              inst_pvalid;
  logic              inst_pready;

  // data load/store port
  logic [ADDR_W-1:0] data_qaddr;
  logic              data_qwrite;
  logic [DATA_W-1:0] data_qdata;
  logic [STRB_W-1:0] data_qstrb;
  logic              data_qvalid;
  logic              data_qready;
  logic [DATA_W-1:0] data_pdata;
  logic              data_perror;
  logic              data_pvalid;
  logic              data_pready;

  // serial link
  logic [LANE_W-1:0] link_out;
  logic              link_out_valid;
  logic              link_out_ready;
  logic [LANE_W-1:0] link_in;
  logic              link_in_valid;

  modport slave (
    input  inst_qaddr, inst_qvalid, inst_pready,
    output inst_qready, inst_pdata, inst_pvalid,
    input  data_qaddr, data_qwrite, data_qdata, data_qstrb, data_qvalid, data_pready,
    output data_qready, data_pdata, data_perror, data_pvalid,
    output link_out, link_out_valid,
    input  link_out_ready, link_in, link_in_valid
  );

  modport master (
    output inst_qaddr, inst_qvalid, inst_pready,
    input  inst_qready, inst_pdata, inst_pvalid,
    output data_qaddr, data_qwrite, data_qdata, data_qstrb, data_qvalid, data_pready,
    input  data_qready, data_pdata, data_perror, data_pvalid,
    input  link_out, link_out_valid,
    output link_out_ready, link_in, link_in_valid
  );
endinterface

// File: rtl/mem_serial_bridge.sv
// mem_serial_bridge: arbitrates an instruction and a data port onto a narrow
// serial link, one transaction outstanding at a time. Outbound frame is
// header, address, then strobe and write data for stores; the reply is either
// the read word or a one-beat write acknowledge.
// Optional response timeout: define MEM_SERIAL_BRIDGE_TIMEOUT_EN.
module mem_serial_bridge #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned LANE_W         = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_serial_bridge_if.slave bus
);

  localparam int unsigned STRB_W     = DATA_W / 8;
  localparam int unsigned ADDR_BEATS = ADDR_W / LANE_W;
  localparam int unsigned STRB_BEATS = (STRB_W + LANE_W - 1) / LANE_W;
  localparam int unsigned DATA_BEATS = DATA_W / LANE_W;
  localparam int unsigned MAX_AD     = (ADDR_BEATS > DATA_BEATS) ? ADDR_BEATS : DATA_BEATS;
  localparam int unsigned MAX_BEATS  = (MAX_AD > STRB_BEATS) ? MAX_AD : STRB_BEATS;
  localparam int unsigned CNT_W      = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam int unsigned SH_W       = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

  // Reject parameter sets the link format cannot represent.
  if (!(LANE_W == 2 || LANE_W == 4 || LANE_W == 8) || (ADDR_W % LANE_W) != 0 ||
      (DATA_W % LANE_W) != 0 || (DATA_W % 8) != 0 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("mem_serial_bridge: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    IDLE, HDR, ADDR, STRB, WDATA, RESP, DELIVER
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rr_q, rr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] strb_q, strb_d;
  logic              write_q, write_d;
  logic              port_q, port_d;
  logic [SH_W-1:0]   shift_q, shift_d;
  logic              link_out_valid_q, link_out_valid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              inst_pvalid_q, inst_pvalid_d;
  logic              data_pvalid_q, data_pvalid_d;
  logic              perror_q, perror_d;

`ifdef MEM_SERIAL_BRIDGE_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  logic idle_c;
  logic pick_data_c;
  logic accept_c;
  logic acc_write_c;
  logic beat_fire_c;

  // Round-robin grant: data wins only when inst is idle or it is data's turn.
  assign idle_c          = (state_q == IDLE) && rst_n;
  assign pick_data_c     = bus.data_qvalid && (!bus.inst_qvalid || rr_q);
  assign accept_c        = idle_c && (bus.inst_qvalid || bus.data_qvalid);
  assign acc_write_c     = pick_data_c && bus.data_qwrite;
  assign beat_fire_c     = link_out_valid_q && bus.link_out_ready;
  assign bus.inst_qready = idle_c && !pick_data_c;
  assign bus.data_qready = idle_c && pick_data_c;

  assign bus.link_out       = shift_q[LANE_W-1:0];
  assign bus.link_out_valid = link_out_valid_q;
  assign bus.inst_pdata     = rdata_q;
  assign bus.inst_pvalid    = inst_pvalid_q;
  assign bus.data_pdata     = rdata_q;
  assign bus.data_pvalid    = data_pvalid_q;
  assign bus.data_perror    = perror_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      rr_q             <= 1'b0;
      addr_q           <= '0;
      wdata_q          <= '0;
      strb_q           <= '0;
      write_q          <= 1'b0;
      port_q           <= 1'b0;
      shift_q          <= '0;
      link_out_valid_q <= 1'b0;
      rdata_q          <= '0;
      inst_pvalid_q    <= 1'b0;
      data_pvalid_q    <= 1'b0;
      perror_q         <= 1'b0;
`ifdef MEM_SERIAL_BRIDGE_TIMEOUT_EN
      tmo_q            <= '0;
`endif
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      rr_q             <= rr_d;
      addr_q           <= addr_d;
      wdata_q          <= wdata_d;
      strb_q           <= strb_d;
      write_q          <= write_d;
      port_q           <= port_d;
      shift_q          <= shift_d;
      link_out_valid_q <= link_out_valid_d;
      rdata_q          <= rdata_d;
      inst_pvalid_q    <= inst_pvalid_d;
      data_pvalid_q    <= data_pvalid_d;
      perror_q         <= perror_d;
`ifdef MEM_SERIAL_BRIDGE_TIMEOUT_EN
      tmo_q            <= tmo_d;
`endif
    end
  end

  // Next-state, frame serialisation and response collection.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_d     = rr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    write_d  = write_q;
    port_d   = port_q;
    shift_d  = shift_q;
    rdata_d  = rdata_q;
    perror_d = perror_q;
`ifdef MEM_SERIAL_BRIDGE_TIMEOUT_EN
    tmo_d    = tmo_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          port_d   = pick_data_c;
          write_d  = acc_write_c;
          addr_d   = pick_data_c ? bus.data_qaddr : bus.inst_qaddr;
          wdata_d  = bus.data_qdata;
          strb_d   = bus.data_qstrb;
          rr_d     = !pick_data_c;
          perror_d = 1'b0;
          shift_d  = SH_W'({pick_data_c, acc_write_c});
          state_d  = HDR;
        end
      end
      HDR: begin
        if (beat_fire_c) begin
          shift_d = SH_W'(addr_q);
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (beat_fire_c) begin
          if (cnt_q == CNT_W'(ADDR_BEATS - 1)) begin
            if (write_q) begin
              shift_d = SH_W'(strb_q);
              state_d = STRB;
            end else begin
              state_d = RESP;
            end
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            shift_d = shift_q >> LANE_W;
          end
        end
      end
      STRB: begin
        if (beat_fire_c) begin
          if (cnt_q == CNT_W'(STRB_BEATS - 1)) begin
            shift_d = SH_W'(wdata_q);
            state_d = WDATA;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            shift_d = shift_q >> LANE_W;
          end
        end
      end
      WDATA: begin
        if (beat_fire_c) begin
          if (cnt_q == CNT_W'(DATA_BEATS - 1)) begin
            state_d = RESP;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            shift_d = shift_q >> LANE_W;
          end
        end
      end
      RESP: begin
        if (bus.link_in_valid) begin
          if (write_q) begin
            perror_d = bus.link_in[0];
            rdata_d  = '0;
            state_d  = DELIVER;
          end else begin
            rdata_d = DATA_W'({bus.link_in, rdata_q} >> LANE_W);
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_BEATS - 1)) begin
              state_d = DELIVER;
            end
          end
        end
`ifdef MEM_SERIAL_BRIDGE_TIMEOUT_EN
        if (bus.link_in_valid) begin
          tmo_d = '0;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          rdata_d  = '0;
          perror_d = port_q;
          state_d  = DELIVER;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end
      DELIVER: begin
        if ((port_q && bus.data_pready) || (!port_q && bus.inst_pready)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Every state starts with a fresh beat count; the reply word starts clear.
    if (state_d != state_q) begin
      cnt_d = '0;
    end
    if (state_d == RESP && state_q != RESP) begin
      rdata_d = '0;
`ifdef MEM_SERIAL_BRIDGE_TIMEOUT_EN
      tmo_d   = '0;
`endif
    end

    link_out_valid_d = (state_d == HDR) || (state_d == ADDR) ||
                       (state_d == STRB) || (state_d == WDATA);
    inst_pvalid_d    = (state_d == DELIVER) && !port_d;
    data_pvalid_d    = (state_d == DELIVER) && port_d;
  end

endmodule

// File: tb/tb_mem_serial_bridge.sv
// tb_mem_serial_bridge: directed and randomized transactions through the bridge,
// outbound frames and delivered responses checked against a beat-list model.
module tb_mem_serial_bridge;
  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned LANE_W         = 4;
  localparam int unsigned TIMEOUT_CYCLES = 255;
  localparam int unsigned STRB_W         = DATA_W / 8;

  logic clk = 1'b0;
  logic rst_n;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [LANE_W-1:0] exp_q[$];

  mem_serial_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LANE_W(LANE_W)) bus ();

  mem_serial_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LANE_W(LANE_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected outbound frame as a list of lane-sized beats, LSB first.
  task automatic build_frame(input bit port, input bit wr, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s);
    exp_q.delete();
    exp_q.push_back(LANE_W'(int'(wr) + 2 * int'(port)));
    for (int i = 0; i < int'(ADDR_W / LANE_W); i++) exp_q.push_back(LANE_W'(a >> (LANE_W * i)));
    if (wr) begin
      for (int i = 0; i < int'((STRB_W + LANE_W - 1) / LANE_W); i++)
        exp_q.push_back(LANE_W'(s >> (LANE_W * i)));
      for (int i = 0; i < int'(DATA_W / LANE_W); i++) exp_q.push_back(LANE_W'(d >> (LANE_W * i)));
    end
  endtask

  task automatic reset_phase(input string tag);
    rst_n = 1'b0;
    bus.inst_qvalid = 1'b1;
    bus.data_qvalid = 1'b1;
    bus.link_out_ready = 1'b0;
    bus.link_in_valid = 1'b0;
    #1;
    check({tag, "_inst_qready"}, bus.inst_qready, 0);
    check({tag, "_data_qready"}, bus.data_qready, 0);
    check({tag, "_lov"}, bus.link_out_valid, 0);
    check({tag, "_link_out"}, bus.link_out, 0);
    check({tag, "_inst_pvalid"}, bus.inst_pvalid, 0);
    check({tag, "_data_pvalid"}, bus.data_pvalid, 0);
    check({tag, "_inst_pdata"}, bus.inst_pdata, 0);
    check({tag, "_data_pdata"}, bus.data_pdata, 0);
    check({tag, "_perror"}, bus.data_perror, 0);
    bus.inst_qvalid = 1'b0;
    bus.data_qvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Wait for the bridge to take a request; the granted port must be exp_port.
  task automatic accept_one(input bit exp_port, output int waited);
    bit got_data;
    waited = 0;
    #1;
    while (!((bus.inst_qvalid && bus.inst_qready) || (bus.data_qvalid && bus.data_qready))
           && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check("grant_port", bus.data_qvalid && bus.data_qready, exp_port);
    check("qready_onehot", bus.inst_qready && bus.data_qready, 0);
    got_data = bus.data_qvalid && bus.data_qready;
    @(negedge clk);
    if (got_data) bus.data_qvalid = 1'b0;
    else bus.inst_qvalid = 1'b0;
  endtask

  // Drive one accepted transaction to completion and compare everything seen.
  task automatic run_txn(input bit port, input logic [DATA_W-1:0] rv, input logic [LANE_W-1:0] ack,
                         input int stall_at, input int abort_at, input int hold, input bit no_reply);
    logic [LANE_W-1:0] got[$];
    logic [LANE_W-1:0] held;
    logic [DATA_W-1:0] exp_pdata, pd_snap;
    bit wr, exp_perr, sv_i, sv_d;
    int budget, nb, n;
    wr = port ? bus.data_qwrite : 1'b0;
    build_frame(port, wr, port ? bus.data_qaddr : bus.inst_qaddr, bus.data_qdata, bus.data_qstrb);
    budget = 0;
    while (got.size() < exp_q.size() && budget < 400) begin
      budget++;
      check("lov_busy", bus.link_out_valid, 1);
      if (abort_at >= 0 && got.size() == abort_at) begin
        reset_phase("midreset");
        repeat (4) begin
          bus.link_out_ready = 1'b1;
          @(negedge clk);
          check("post_reset_lov", bus.link_out_valid, 0);
          check("post_reset_pvalid", bus.data_pvalid || bus.inst_pvalid, 0);
        end
        bus.link_out_ready = 1'b0;
        return;
      end
      if (stall_at >= 0 && got.size() == stall_at) begin
        held = bus.link_out;
        bus.link_out_ready = 1'b0;
        bus.link_in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("stall_link_out", bus.link_out, held);
          check("stall_lov", bus.link_out_valid, 1);
        end
        stall_at = -1;
      end
      bus.link_out_ready = ($urandom_range(3) != 0);
      bus.link_in_valid = 1'($urandom_range(1));
      bus.link_in = LANE_W'($urandom);
      if (bus.link_out_ready) got.push_back(bus.link_out);
      @(negedge clk);
    end
    bus.link_out_ready = 1'b0;
    bus.link_in_valid = 1'b0;
    check("out_beat_count", got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("out_beat%0d", i), (i < got.size()) ? got[i] : 'x, exp_q[i]);
    check("lov_resp", bus.link_out_valid, 0);

    if (no_reply) begin
      n = 0;
      while (!(port ? bus.data_pvalid : bus.inst_pvalid) && n < int'(TIMEOUT_CYCLES) + 20) begin
        @(negedge clk);
        n++;
      end
      check("timeout_latency", n, TIMEOUT_CYCLES);
      exp_pdata = '0;
      exp_perr = port;
    end else begin
      nb = wr ? 1 : int'(DATA_W / LANE_W);
      for (int i = 0; i < nb; i++) begin
        repeat ($urandom_range(2)) begin
          check("pvalid_early", port ? bus.data_pvalid : bus.inst_pvalid, 0);
          @(negedge clk);
        end
        bus.link_in_valid = 1'b1;
        bus.link_in = wr ? ack : LANE_W'(rv >> (LANE_W * i));
        @(negedge clk);
        bus.link_in_valid = 1'b0;
      end
      exp_pdata = wr ? '0 : rv;
      exp_perr = wr ? ack[0] : 1'b0;
    end

    check("pvalid_own", port ? bus.data_pvalid : bus.inst_pvalid, 1);
    check("pvalid_other", port ? bus.inst_pvalid : bus.data_pvalid, 0);
    check("pdata", port ? bus.data_pdata : bus.inst_pdata, exp_pdata);
    if (port) check("perror", bus.data_perror, exp_perr);
    pd_snap = port ? bus.data_pdata : bus.inst_pdata;

    sv_i = bus.inst_qvalid;
    sv_d = bus.data_qvalid;
    bus.inst_qvalid = 1'b1;
    bus.data_qvalid = 1'b1;
    for (int k = 0; k < hold; k++) begin
      #1;
      check("hold_qready", bus.inst_qready || bus.data_qready, 0);
      check("hold_pvalid", port ? bus.data_pvalid : bus.inst_pvalid, 1);
      check("hold_pdata", port ? bus.data_pdata : bus.inst_pdata, pd_snap);
      @(negedge clk);
    end
    if (port) bus.data_pready = 1'b1;
    else bus.inst_pready = 1'b1;
    #1;
    check("no_bypass_qready", bus.inst_qready || bus.data_qready, 0);
    @(negedge clk);
    bus.inst_pready = 1'b0;
    bus.data_pready = 1'b0;
    bus.inst_qvalid = sv_i;
    bus.data_qvalid = sv_d;
    check("pvalid_cleared", bus.inst_pvalid || bus.data_pvalid, 0);
    check("lov_idle", bus.link_out_valid, 0);
  endtask

  initial begin
    int w;
    bit p;
    bus.inst_qaddr = '0;  bus.inst_qvalid = 1'b0; bus.inst_pready = 1'b0;
    bus.data_qaddr = '0;  bus.data_qwrite = 1'b0; bus.data_qdata = '0;
    bus.data_qstrb = '0;  bus.data_qvalid = 1'b0; bus.data_pready = 1'b0;
    bus.link_out_ready = 1'b0; bus.link_in = '0; bus.link_in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    @(negedge clk);
    reset_phase("reset");

    // Read 0x1000_0040 on the data port, accepted on the first edge out of reset,
    // with a five-cycle stall in the middle of the address beats.
    bus.data_qaddr = 32'h1000_0040;
    bus.data_qwrite = 1'b0;
    bus.data_qvalid = 1'b1;
    accept_one(1'b1, w);
    check("first_accept_latency", w, 0);
    run_txn(1'b1, 32'h1234_5678, 4'h0, 4, -1, 0, 1'b0);

    // Write 0xDEAD_BEEF strobe 0x3 to 0x4, acknowledged with error; long pready stall.
    bus.data_qaddr = 32'h4;
    bus.data_qwrite = 1'b1;
    bus.data_qdata = 32'hDEAD_BEEF;
    bus.data_qstrb = 4'h3;
    bus.data_qvalid = 1'b1;
    accept_one(1'b1, w);
    run_txn(1'b1, '0, 4'h1, -1, -1, 10, 1'b0);

    // Contention twice in a row: grants alternate inst, data, inst, data.
    for (int r = 0; r < 2; r++) begin
      bus.inst_qaddr = $urandom;
      bus.data_qaddr = $urandom;
      bus.data_qwrite = 1'b0;
      bus.inst_qvalid = 1'b1;
      bus.data_qvalid = 1'b1;
      accept_one(1'b0, w);
      run_txn(1'b0, $urandom, 4'h0, -1, -1, 1, 1'b0);
      accept_one(1'b1, w);
      run_txn(1'b1, $urandom, 4'h0, -1, -1, 1, 1'b0);
    end

    // Reset in the middle of write data, then a normal read.
    bus.data_qaddr = $urandom;
    bus.data_qwrite = 1'b1;
    bus.data_qdata = $urandom;
    bus.data_qstrb = 4'hF;
    bus.data_qvalid = 1'b1;
    accept_one(1'b1, w);
    run_txn(1'b1, '0, 4'h0, -1, 13, 0, 1'b0);
    bus.data_qaddr = $urandom;
    bus.data_qwrite = 1'b0;
    bus.data_qvalid = 1'b1;
    accept_one(1'b1, w);
    run_txn(1'b1, $urandom, 4'h0, -1, -1, 0, 1'b0);

    // Randomized single-port traffic.
    for (int t = 0; t < 24; t++) begin
      p = 1'($urandom_range(1));
      bus.inst_qaddr = $urandom;
      bus.data_qaddr = $urandom;
      bus.data_qwrite = 1'($urandom_range(1));
      bus.data_qdata = $urandom;
      bus.data_qstrb = STRB_W'($urandom);
      if (p) bus.data_qvalid = 1'b1;
      else bus.inst_qvalid = 1'b1;
      accept_one(p, w);
      run_txn(p, $urandom, LANE_W'($urandom), ($urandom_range(3) == 0) ? 3 : -1, -1,
              $urandom_range(3), 1'b0);
    end

`ifdef MEM_SERIAL_BRIDGE_TIMEOUT_EN
    // Unanswered read times out with an error.
    bus.data_qaddr = $urandom;
    bus.data_qwrite = 1'b0;
    bus.data_qvalid = 1'b1;
    accept_one(1'b1, w);
    run_txn(1'b1, '0, 4'h0, -1, -1, 0, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
